// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end: opcode constants,
// fetch state encoding and PC width.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, sequential increment and redirect select.
// A redirect always wins over the increment in the same cycle.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    input  logic            redir_en,
    input  logic [PC_W-1:0] redir_target,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= align_word(RESET_PC);
        end else if (redir_en) begin
            pc <= align_word(redir_target);
        end else if (inc_en) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, instruction register
// with valid/ready towards the decoder, branch redirect with in-flight kill.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_REQ  | request driven to memory at pc, waiting for imem_req_ready
// S_WAIT | request accepted, waiting for the single response pulse
// S_HOLD | instruction register valid, waiting for downstream if_ready
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [5:0]      if_op,
    output logic [5:0]      if_func,
    output logic            proto_err
);

    fetch_state_t    state;
    logic            kill;
    logic            req_valid_q;
    logic            if_valid_q;
    logic [31:0]     if_instr_q;
    logic [PC_W-1:0] if_pc_q;
    logic            proto_err_q;
    logic [PC_W-1:0] pc;
    logic            req_fire;
    logic            rsp_accept;

    // A handshake only counts once the registered valid is actually driven.
    assign req_fire   = (state == S_REQ) && req_valid_q && imem_req_ready;
    assign rsp_accept = (state == S_WAIT) && imem_rsp_valid && !kill && !br_taken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_en       (rsp_accept),
        .redir_en     (br_taken),
        .redir_target (br_target),
        .pc           (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            kill        <= 1'b0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (imem_rsp_valid && (state != S_WAIT)) begin
                proto_err_q <= 1'b1;
            end

            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state       <= S_WAIT;
                        kill        <= br_taken;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || br_taken) begin
                            state       <= S_REQ;
                            kill        <= 1'b0;
                            req_valid_q <= 1'b1;
                        end else begin
                            state      <= S_HOLD;
                            if_instr_q <= imem_rsp_data;
                            if_pc_q    <= pc;
                            if_valid_q <= 1'b1;
                        end
                    end else if (br_taken) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect drops the held word even if it is being consumed.
                    if (br_taken || if_ready) begin
                        state       <= S_REQ;
                        if_valid_q  <= 1'b0;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_REQ;
                    kill        <= 1'b0;
                    req_valid_q <= 1'b0;
                    if_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_op          = if_instr_q[31:26];
    assign if_func        = if_instr_q[5:0];
    assign proto_err      = proto_err_q;

endmodule
